cfi_mailbox_responder: RTL
==========================

Name: cfi_mailbox_responder

Overview:
- AXI subordinate at the mailbox end of the CFI log path.
- Accepts the log burst and the doorbell write issued by the CFI backend, stores the log words, and presents the complete log record to the consumer (CFI checker / security core) through a valid/ready handshake.
- Sits on the AXI crossbar at the mailbox address window.

Parameters:
- BASE_ADDR, 64'h0000_0000_1040_4000, base of the log word window.
- NUM_WORDS, 8, number of 32-bit log words; doorbell register sits at BASE_ADDR + 4*NUM_WORDS.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- axi_req_i  in  ariane_axi::req_t  AXI request from crossbar
- axi_rsp_o  out  ariane_axi::resp_t  AXI response to crossbar
- log_o  out  32*NUM_WORDS  captured log record, word k at bits [32k+31:32k]
- log_valid_o  out  1  record complete and pending
- log_ready_i  in  1  consumer accepts record
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - FSM goes to IDLE; storage, log_o, log_valid_o and all axi_rsp_o ready/valid fields go to 0.
  - An in-flight transaction is dropped; no B or R beat is emitted.
- Single transaction at a time. Write has priority over read when aw_valid and ar_valid are both high in IDLE.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - aw_ready = 1 combinationally.
  - On aw_valid: latch addr, len, id; clear beat counter (8 bits) and error flag; next state WDATA.
- WDATA:
  - w_ready = 1.
  - Each w_valid beat writes to word index = addr[4:2] + beat counter, then the beat counter increments.
  - Only w.data[31:0] is used; strb[3:0] are per-byte enables.
  - A beat is discarded and the error flag set when any of these holds:
    - index >= NUM_WORDS within the log window
    - the window is not a valid target
    - log_valid_o == 1 (captured record is protected)
  - Doorbell: a beat at BASE_ADDR + 4*NUM_WORDS with data[0] = 1 arms a trigger. Doorbell while log_valid_o == 1 is ignored and sets the error flag.
  - On w.last: next state WRESP. If w.last arrives at beat counter != len, the error flag is set.
  - If the beat count exceeds len without w.last, further beats are accepted and discarded with the error flag set.
- WRESP:
  - b_valid = 1, b.id = latched id, b.resp = SLVERR (2'b10) if the error flag is set, else OKAY.
  - On b_ready: next state IDLE.
  - If the trigger is armed, log_valid_o goes high the cycle after the B handshake.
- log_valid_o:
  - Held, with log_o stable, until log_valid_o && log_ready_i.
  - Cleared the following cycle; storage is not cleared.
- Any address outside [BASE_ADDR, BASE_ADDR + 4*NUM_WORDS]: all beats discarded, SLVERR.
- Burst type is ignored; all bursts are treated as INCR.

Optional Feature:
- Macro CFI_MBOX_READBACK_EN.
- Defined:
  - IDLE sets ar_ready = 1 when aw_valid is low and latches addr, len, id.
  - RDATA returns len+1 beats. r.data[31:0] = word at index addr[4:2] + beat; upper bits are 0.
  - Doorbell address reads {31'b0, log_valid_o}.
  - Out-of-window index returns 0 with SLVERR.
  - r.last is set on the final beat; each beat is held until r_ready.
- Undefined:
  - The AR request is still accepted so the bus never hangs.
  - len+1 beats are returned with data 0, SLVERR, and r.last on the final beat.

Test Plan:
- Log burst: AW addr 0x10404000, len 7, beats 0x11..0x88, then doorbell write of 1 at 0x10404020 → both B OKAY; log_valid_o rises 1 cycle after the second B; log_o word0 = 0x11, word7 = 0x88.
- log_ready_i held low 20 cycles → log_valid_o stays 1 and log_o is stable. Pulse log_ready_i → log_valid_o = 0 next cycle.
- Write while pending: burst to word 2 with log_valid_o = 1 → B SLVERR, word 2 unchanged.
- Overrun: AW addr 0x10404018, len 3 → words 6 and 7 written, beats 3–4 discarded, B SLVERR.
- Protocol error: aw len 3 with w.last on beat 1 → B SLVERR, state returns to IDLE.
- Reset mid-WDATA after 3 beats → no B emitted, log_o = 0. A new burst then completes normally.
- With CFI_MBOX_READBACK_EN: read 0x10404000, len 7 after a capture → 8 beats matching the written data, r.last on beat 8.

Source files
------------

// File: rtl/cfi_mailbox_responder.sv
// CFI log mailbox: AXI subordinate that captures the log burst plus doorbell and hands the record to the consumer.
// Define CFI_MBOX_READBACK_EN to enable AXI readback of the log words and doorbell status.
package ariane_axi;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module cfi_mailbox_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1040_4000,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  ariane_axi::req_t         axi_req_i,
  output ariane_axi::resp_t        axi_rsp_o,
  output logic [32*NUM_WORDS-1:0]  log_o,
  output logic                     log_valid_o,
  input  logic                     log_ready_i,
  output logic                     busy_o
);
  localparam logic [63:0] DB_ADDR = BASE_ADDR + 64'(4 * NUM_WORDS);
  localparam int unsigned IW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e      r_state, w_state_nxt;
  logic [63:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [3:0]  r_id;
  logic        r_err;
  logic        r_past;
  logic        r_trig;
  logic        r_log_valid;
  logic [31:0] r_mem [NUM_WORDS];

  logic        w_in_win, w_is_db, w_idx_ok, w_target_ok, w_beat_err, w_rlast;
  logic [63:0] w_idx;
  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;
  logic        w_unused;

  // Target is decided by the start address; beats past the last log word never spill into the doorbell.
  assign w_in_win    = (r_addr >= BASE_ADDR) && (r_addr < DB_ADDR);
  assign w_is_db     = (r_addr == DB_ADDR);
  assign w_idx       = ((r_addr - BASE_ADDR) >> 2) + 64'(r_beat);
  assign w_idx_ok    = w_in_win && (w_idx < 64'(NUM_WORDS));
  assign w_target_ok = w_idx_ok || (w_is_db && (r_beat == '0));
  assign w_beat_err  = r_past || !w_target_ok || r_log_valid ||
                       (axi_req_i.w.last && (r_beat != r_len));
  assign w_rlast     = (r_beat == r_len);

  assign log_valid_o = r_log_valid;
  assign busy_o      = (r_state != IDLE);
  assign w_unused    = ^{axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.ar.size,
                         axi_req_i.ar.burst, axi_req_i.w.data[63:32], axi_req_i.w.strb[7:4]};

  always_comb begin
    log_o = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      log_o[32*k +: 32] = r_mem[k];
    end
  end

  always_comb begin
    w_rdata = '0;
    w_rresp = 2'b10;
`ifdef CFI_MBOX_READBACK_EN
    if (w_idx_ok) begin
      w_rdata = r_mem[w_idx[IW-1:0]];
      w_rresp = 2'b00;
    end else if (w_is_db && (r_beat == '0)) begin
      w_rdata = {31'b0, r_log_valid};
      w_rresp = 2'b00;
    end
`endif
  end

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    axi_rsp_o   = '0;
    if (!rst_i) begin
      case (r_state)
        IDLE: begin
          axi_rsp_o.aw_ready = 1'b1;
          axi_rsp_o.ar_ready = !axi_req_i.aw_valid;
          if (axi_req_i.aw_valid)      w_state_nxt = WDATA;
          else if (axi_req_i.ar_valid) w_state_nxt = RDATA;
        end
        WDATA: begin
          axi_rsp_o.w_ready = 1'b1;
          if (axi_req_i.w_valid && axi_req_i.w.last) w_state_nxt = WRESP;
        end
        WRESP: begin
          axi_rsp_o.b_valid = 1'b1;
          axi_rsp_o.b.id    = r_id;
          axi_rsp_o.b.resp  = r_err ? 2'b10 : 2'b00;
          if (axi_req_i.b_ready) w_state_nxt = IDLE;
        end
        RDATA: begin
          axi_rsp_o.r_valid = 1'b1;
          axi_rsp_o.r.id    = r_id;
          axi_rsp_o.r.data  = {32'h0, w_rdata};
          axi_rsp_o.r.resp  = w_rresp;
          axi_rsp_o.r.last  = w_rlast;
          if (axi_req_i.r_ready && w_rlast) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_id        <= '0;
      r_err       <= 1'b0;
      r_past      <= 1'b0;
      r_trig      <= 1'b0;
      r_log_valid <= 1'b0;
      for (int unsigned k = 0; k < NUM_WORDS; k++) r_mem[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_log_valid && log_ready_i) r_log_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          r_err  <= 1'b0;
          r_past <= 1'b0;
          r_trig <= 1'b0;
          if (axi_req_i.aw_valid) begin
            r_addr <= axi_req_i.aw.addr;
            r_len  <= axi_req_i.aw.len;
            r_id   <= axi_req_i.aw.id;
          end else if (axi_req_i.ar_valid) begin
            r_addr <= axi_req_i.ar.addr;
            r_len  <= axi_req_i.ar.len;
            r_id   <= axi_req_i.ar.id;
          end
        end
        WDATA: begin
          if (axi_req_i.w_valid) begin
            if (w_idx_ok && !r_past && !r_log_valid) begin
              for (int unsigned b = 0; b < 4; b++) begin
                if (axi_req_i.w.strb[b]) r_mem[w_idx[IW-1:0]][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
              end
            end
            if (w_is_db && (r_beat == '0) && !r_past && !r_log_valid && axi_req_i.w.data[0])
              r_trig <= 1'b1;
            if (w_beat_err) r_err <= 1'b1;
            // Sticky overrun marker keeps the 8-bit beat counter's wrap from re-enabling writes.
            if (w_rlast && !axi_req_i.w.last) r_past <= 1'b1;
            r_beat <= r_beat + 8'd1;
          end
        end
        WRESP: begin
          if (axi_req_i.b_ready && r_trig) r_log_valid <= 1'b1;
        end
        RDATA: begin
          if (axi_req_i.r_ready) r_beat <= r_beat + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
